rab_inval_ctrl: RTL
===================

RAB_INVAL_CTRL -- requirements
Module: rab_inval_ctrl

Interface
REQ-001 SHALL have parameter NUM_SLICES, default 16: number of L1 RAB slices walked.
REQ-002 SHALL have parameter AW, default 32: address width of range bounds.
REQ-003 SHALL have ports clk_i in 1 (clock) and rst_i in 1 (reset); one clock; reset is synchronous and active-high.
REQ-004 SHALL have inv_valid_i in 1: invalidation request valid.
REQ-005 SHALL have inv_ready_o out 1: request accepted when valid&&ready.
REQ-006 SHALL have inv_start_i in AW and inv_end_i in AW: inclusive invalidation range.
REQ-007 SHALL have inv_done_o out 1: one-cycle completion pulse.
REQ-008 SHALL have inv_err_o out 1: valid with inv_done_o; range illegal (start > end).
REQ-009 SHALL have inv_count_o out $clog2(NUM_SLICES+1): slices cleared; valid with inv_done_o.
REQ-010 SHALL have slc_idx_o out $clog2(NUM_SLICES): slice addressed.
REQ-011 SHALL have slc_rd_o out 1: slice read strobe.
REQ-012 SHALL have slc_start_i, slc_end_i in AW and slc_en_i in 1: slice contents, valid the cycle after slc_rd_o.
REQ-013 SHALL have slc_clr_o out 1: clear enable bit of slice slc_idx_o this cycle.
REQ-014 SHALL have hold_o out 1: stall new translations while walking.

Function
REQ-015 SHALL implement FSM states IDLE, READ, CHECK, CLEAR, DONE.
REQ-016 SHALL assert inv_ready_o only in IDLE and never while rst_i is high.
REQ-017 On accept in IDLE, SHALL register start/end, clear counter, set index 0, enter READ; if start > end, SHALL enter DONE directly with err set.
REQ-018 READ: SHALL assert slc_rd_o for one cycle with slc_idx_o = index, then enter CHECK.
REQ-019 CHECK: SHALL hit iff slc_en_i && slc_start_i <= end && start <= slc_end_i (unsigned, full AW compare).
REQ-020 CHECK hit: SHALL enter CLEAR; miss: SHALL advance index and enter READ, or enter DONE if index == NUM_SLICES-1.
REQ-021 CLEAR: SHALL assert slc_clr_o one cycle with same slc_idx_o, increment counter, then advance as in REQ-020.
REQ-022 DONE: SHALL pulse inv_done_o for exactly one cycle with inv_count_o/inv_err_o stable, then enter IDLE.
REQ-023 Latency accept-to-done SHALL be 2*NUM_SLICES + hits + 1 cycles; illegal range SHALL complete in 1 cycle.
REQ-024 hold_o SHALL be high in READ, CHECK, CLEAR, DONE; low in IDLE.
REQ-025 slc_rd_o and slc_clr_o SHALL never be high in the same cycle; index SHALL never exceed NUM_SLICES-1.
REQ-026 Counter SHALL saturate at NUM_SLICES (no wrap).
REQ-027 inv_valid_i while not ready SHALL be ignored; inputs SHALL be sampled only at accept.

Reset
REQ-028 rst_i high SHALL force IDLE; all outputs 0 (inv_ready_o 0), index and counter 0, stored range 0.
REQ-029 Reset mid-walk SHALL abort without inv_done_o and without further slc_clr_o from the next cycle; no partial state survives.

Structure
REQ-030 Package rab_inval_pkg SHALL hold the FSM state enum and the index/count width helpers.
REQ-031 One sub-module rab_range_overlap SHALL hold the REQ-019 compare; all state lives in rab_inval_ctrl.

Verification
REQ-032 NUM_SLICES=4; slices {0x1000-0x1FFF en},{0x3000-0x3FFF en},{0x2000-0x2FFF dis},{0x8000-0x8FFF en}; inv 0x1800-0x3100 -> clr on idx 0,1 only, count=2, done 11 cycles after accept.
REQ-033 Inv 0x9000-0x9FFF (no overlap) -> no slc_clr_o, count=0, done after 9 cycles.
REQ-034 Inv start=0x2000,end=0x1000 -> no slc_rd_o, done next cycle, err=1, count=0.
REQ-035 Boundary: slice 0x1000-0x1FFF, inv 0x1FFF-0x1FFF -> hit; inv 0x2000-0x2000 -> miss.
REQ-036 rst_i asserted in CHECK of idx 1 -> next cycle IDLE, all outputs 0, no done; new request then completes normally.
REQ-037 inv_valid_i held high during walk -> second request accepted only on the cycle after inv_done_o; hold_o low exactly that one cycle.

Source files
------------

// File: rtl/rab_inval_pkg.sv
// rab_inval_pkg: shared types and width helpers for the RAB range-invalidation
// controller.
//   inv_state_e : walker FSM states
//   idx_width() : bits needed to address NUM_SLICES slices (never below 1)
//   cnt_width() : bits needed to count 0..NUM_SLICES cleared slices
package rab_inval_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_READ,
    ST_CHECK,
    ST_CLEAR,
    ST_DONE
  } inv_state_e;

  // A single-slice configuration still needs a 1-bit index port.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int cnt_width(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/rab_range_overlap.sv
// rab_range_overlap: decides whether one enabled RAB slice intersects the
// requested invalidation range. Both ranges are inclusive and compared as
// unsigned full-width values.
//   en        : slice enable bit
//   slc_start : slice lower bound
//   slc_end   : slice upper bound
//   inv_start : invalidation lower bound
//   inv_end   : invalidation upper bound
//   hit       : slice is enabled and overlaps the invalidation range
module rab_range_overlap #(
  parameter int AW = 32
) (
  input  logic          en,
  input  logic [AW-1:0] slc_start,
  input  logic [AW-1:0] slc_end,
  input  logic [AW-1:0] inv_start,
  input  logic [AW-1:0] inv_end,
  output logic          hit
);

  // Two inclusive intervals overlap unless one lies wholly past the other.
  assign hit = en && (slc_start <= inv_end) && (inv_start <= slc_end);

endmodule

// File: rtl/rab_inval_ctrl.sv
// rab_inval_ctrl: walks every L1 RAB slice, reads its bounds and clears the
// enable bit of each enabled slice that overlaps an inclusive invalidation
// range. New translations are held off for the duration of the walk.
//   clk_i, rst_i        : clock, synchronous active-high reset
//   inv_valid_i/ready_o : request handshake (accepted when both high)
//   inv_start_i/end_i   : inclusive invalidation range, sampled at accept
//   inv_done_o          : one-cycle completion pulse
//   inv_err_o           : range was illegal (start > end), valid with done
//   inv_count_o         : number of slices cleared, valid with done
//   slc_idx_o           : slice currently addressed
//   slc_rd_o            : slice read strobe; contents return next cycle
//   slc_start_i/end_i/en_i : slice contents
//   slc_clr_o           : clear enable bit of slice slc_idx_o
//   hold_o              : stall new translations while the walk is active
module rab_inval_ctrl
  import rab_inval_pkg::*;
#(
  parameter int NUM_SLICES = 16,
  parameter int AW         = 32
) (
  input  logic                               clk_i,
  input  logic                               rst_i,
  input  logic                               inv_valid_i,
  output logic                               inv_ready_o,
  input  logic [AW-1:0]                      inv_start_i,
  input  logic [AW-1:0]                      inv_end_i,
  output logic                               inv_done_o,
  output logic                               inv_err_o,
  output logic [cnt_width(NUM_SLICES)-1:0]   inv_count_o,
  output logic [idx_width(NUM_SLICES)-1:0]   slc_idx_o,
  output logic                               slc_rd_o,
  input  logic [AW-1:0]                      slc_start_i,
  input  logic [AW-1:0]                      slc_end_i,
  input  logic                               slc_en_i,
  output logic                               slc_clr_o,
  output logic                               hold_o
);

  localparam int IDX_W = idx_width(NUM_SLICES);
  localparam int CNT_W = cnt_width(NUM_SLICES);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_SLICES - 1);
  localparam logic [CNT_W-1:0] MAX_CNT  = CNT_W'(NUM_SLICES);

  inv_state_e       state_reg, state_next;
  logic [IDX_W-1:0] idx_reg, idx_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic [AW-1:0]    start_reg, start_next;
  logic [AW-1:0]    end_reg, end_next;
  logic             err_reg, err_next;
  logic             rd_reg, clr_reg, done_reg, hold_reg;
  logic             hit;

  rab_range_overlap #(
    .AW(AW)
  ) u_overlap (
    .en        (slc_en_i),
    .slc_start (slc_start_i),
    .slc_end   (slc_end_i),
    .inv_start (start_reg),
    .inv_end   (end_reg),
    .hit       (hit)
  );

  always_comb begin
    state_next = state_reg;
    idx_next   = idx_reg;
    cnt_next   = cnt_reg;
    start_next = start_reg;
    end_next   = end_reg;
    err_next   = err_reg;
    case (state_reg)
      ST_IDLE: begin
        if (inv_valid_i) begin
          start_next = inv_start_i;
          end_next   = inv_end_i;
          cnt_next   = '0;
          idx_next   = '0;
          err_next   = (inv_start_i > inv_end_i);
          // An inverted range never touches the slice table.
          state_next = (inv_start_i > inv_end_i) ? ST_DONE : ST_READ;
        end
      end
      ST_READ: state_next = ST_CHECK;
      ST_CHECK: begin
        if (hit) begin
          state_next = ST_CLEAR;
        end else if (idx_reg == LAST_IDX) begin
          state_next = ST_DONE;
        end else begin
          idx_next   = idx_reg + IDX_W'(1);
          state_next = ST_READ;
        end
      end
      ST_CLEAR: begin
        if (cnt_reg != MAX_CNT) begin
          cnt_next = cnt_reg + CNT_W'(1);
        end
        if (idx_reg == LAST_IDX) begin
          state_next = ST_DONE;
        end else begin
          idx_next   = idx_reg + IDX_W'(1);
          state_next = ST_READ;
        end
      end
      ST_DONE: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  // Strobe outputs are registered from the next state so they line up with
  // the state they belong to without any decode glitches.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_reg <= ST_IDLE;
      idx_reg   <= '0;
      cnt_reg   <= '0;
      start_reg <= '0;
      end_reg   <= '0;
      err_reg   <= 1'b0;
      rd_reg    <= 1'b0;
      clr_reg   <= 1'b0;
      done_reg  <= 1'b0;
      hold_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      idx_reg   <= idx_next;
      cnt_reg   <= cnt_next;
      start_reg <= start_next;
      end_reg   <= end_next;
      err_reg   <= err_next;
      rd_reg    <= (state_next == ST_READ);
      clr_reg   <= (state_next == ST_CLEAR);
      done_reg  <= (state_next == ST_DONE);
      hold_reg  <= (state_next != ST_IDLE);
    end
  end

  // Ready is gated by reset directly so no request can be taken while reset
  // is being applied, even though the state register still reads IDLE.
  assign inv_ready_o = (state_reg == ST_IDLE) && !rst_i;
  assign inv_done_o  = done_reg;
  assign inv_err_o   = err_reg;
  assign inv_count_o = cnt_reg;
  assign slc_idx_o   = idx_reg;
  assign slc_rd_o    = rd_reg;
  assign slc_clr_o   = clr_reg;
  assign hold_o      = hold_reg;

endmodule
